rename_reg_file: RTL and testbench
==================================

RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
- REQ-001 Parameters, one per line: name, default, meaning.
  - XLEN, 32, register data width.
  - NREG, 32, architectural register count (power of 2); AW = log2(NREG).
  - ROB_WIDTH, 4, ROB index width.
  - NRP, 2, number of read ports.
- REQ-002 Ports, one per line: name, direction, width, meaning.
  - clk_in, in, 1, single clock.
  - rst_in, in, 1, synchronous active-high reset.
  - rdy_in, in, 1, global enable; low freezes all state.
  - clr_in, in, 1, misprediction flush.
  - issue_valid, in, 1, new instruction renames its destination.
  - issue_rd, in, AW, destination register.
  - issue_rob_idx, in, ROB_WIDTH, ROB tag of the issuing instruction.
  - commit_valid, in, 1, ROB retires an instruction with a destination.
  - commit_rd, in, AW, retired destination register.
  - commit_val, in, XLEN, retired value.
  - commit_rob_idx, in, ROB_WIDTH, tag of the retiring instruction.
  - rp_addr, in, NRP*AW, read addresses; port p uses slice p.
  - rp_val, out, NRP*XLEN, read values.
  - rp_busy, out, NRP, 1 = value pending in the ROB.
  - rp_tag, out, NRP*ROB_WIDTH, producing ROB tag when busy, else 0.
  - busy_cnt, out, AW+1, registered count of busy registers.

Function
- REQ-003 State per register: val (XLEN), busy (1 bit), tag (ROB_WIDTH). Tag 0 is a legal ROB index; busy alone marks validity.
- REQ-004 Register 0 always reads val=0, busy=0, tag=0; issue and commit to register 0 are ignored.
- REQ-005 Read ports are combinational and independent; any number of ports may address the same register.
- REQ-006 Commit bypass: if commit_valid, commit_rd==rp_addr!=0, busy is set and tag==commit_rob_idx, the port returns val=commit_val, busy=0, tag=0 in the same cycle.
- REQ-007 Reads reflect state before this cycle's issue; a same-cycle issue to the addressed register does not change the port outputs. The issuing instruction's sources are read before its rd is renamed.
- REQ-008 On commit (rdy_in=1, rd!=0): val[rd] <= commit_val unconditionally. If busy[rd] and tag[rd]==commit_rob_idx, busy is cleared; otherwise busy and tag are unchanged (a newer rename exists).
- REQ-009 On issue (rdy_in=1, rd!=0): busy[rd] <= 1 and tag[rd] <= issue_rob_idx.
- REQ-010 Same-cycle issue and commit to the same rd: issue wins for busy and tag; val still takes commit_val.
- REQ-011 clr_in=1 (rdy_in=1): all busy and tag are cleared and busy_cnt <= 0. A same-cycle commit still writes val. A same-cycle issue is discarded.
- REQ-012 busy_cnt equals the number of registers with busy=1 after the edge. It is updated each cycle by the net of one set and one clear, with no change when the set and clear hit the same register or the set re-renames an already-busy register. Range 0..NREG-1; it never wraps.
- REQ-013 rdy_in=0: no state changes. Read ports still respond combinationally, including the bypass.
- REQ-014 Latency: a write is visible on read ports from the cycle after the edge, except for the REQ-006 bypass.

Reset
- REQ-015 rst_in=1 at the clock edge: all val <= 0, busy <= 0, tag <= 0, busy_cnt <= 0. Reset has priority over rdy_in, clr_in, issue and commit.
- REQ-016 Reset mid-operation discards in-flight renames. From the first cycle after reset, all ports read val=0, busy=0, tag=0.

Verification
- REQ-017 The bench shall cover these directed scenarios:
  - Issue x5 with tag 3, then read x5 -> busy=1, tag=3, busy_cnt=1. Commit x5 tag 3 with val 0xDEADBEEF -> same-cycle read gives val=0xDEADBEEF, busy=0; next cycle busy_cnt=0.
  - Issue x7 tag 2, then issue x7 tag 6, then commit x7 tag 2 with val 0x11 -> val[x7]=0x11, busy=1, tag=6, busy_cnt=1.
  - Same cycle: issue x9 tag 4 and commit x9 tag 1 (x9 busy with tag 1) -> busy=1, tag=4, val=commit value, busy_cnt unchanged.
  - Rename x1..x4, assert clr_in together with issue x8 -> all busy=0, busy_cnt=0, x8 not busy, earlier committed values retained.
  - Issue and commit to x0 with val 0xFFFF -> x0 reads 0, busy_cnt stays 0. With rdy_in=0, issue x3 -> no state change.
  - Assert rst_in while 10 registers are busy -> next cycle all ports read 0/0/0 and busy_cnt=0. Both ports on the same address return identical results.

Source files
------------

// File: rtl/rename_reg_file.sv
// Register file with rename status for an out-of-order core: each architectural
// register holds a value, a busy flag and the ROB tag of its pending producer.
// Ports: clk_in/rst_in (sync, active-high)/rdy_in (global enable)/clr_in (flush);
//   issue_* renames a destination, commit_* retires a value from the ROB;
//   rp_addr -> rp_val/rp_busy/rp_tag are NRP combinational read ports;
//   busy_cnt is the registered number of busy registers.
// Reads are combinational with a same-cycle commit bypass; state updates land on the next edge.
module rename_reg_file #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int ROB_WIDTH = 4,
    parameter int NRP       = 2,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clr_in,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_rd,
    input  logic [ROB_WIDTH-1:0]     issue_rob_idx,
    input  logic                     commit_valid,
    input  logic [AW-1:0]            commit_rd,
    input  logic [XLEN-1:0]          commit_val,
    input  logic [ROB_WIDTH-1:0]     commit_rob_idx,
    input  logic [NRP*AW-1:0]        rp_addr,
    output logic [NRP*XLEN-1:0]      rp_val,
    output logic [NRP-1:0]           rp_busy,
    output logic [NRP*ROB_WIDTH-1:0] rp_tag,
    output logic [AW:0]              busy_cnt
);

    logic [XLEN-1:0]      val_q [NREG];
    logic [ROB_WIDTH-1:0] tag_q [NREG];
    logic [NREG-1:0]      busy_q;
    logic [AW:0]          cnt_q;

    logic commit_en;
    logic commit_hit;
    logic issue_en;
    logic cnt_inc;
    logic cnt_dec;

    // Register 0 is hardwired: writes to it are simply never enabled.
    assign commit_en  = rdy_in && commit_valid && (commit_rd != '0);
    // The retiring instruction is still the newest producer of its rd.
    assign commit_hit = commit_en && busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_idx);
    assign issue_en   = rdy_in && !clr_in && issue_valid && (issue_rd != '0);

    // Re-renaming an already busy register adds nothing; a clear that the
    // same-cycle issue overrides removes nothing.
    assign cnt_inc = issue_en && !busy_q[issue_rd];
    assign cnt_dec = commit_hit && !(issue_en && (issue_rd == commit_rd));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else if (rdy_in) begin
            // Retired values are architectural even when a newer rename or a
            // flush is in flight.
            if (commit_en) begin
                val_q[commit_rd] <= commit_val;
            end
            if (clr_in) begin
                for (int i = 0; i < NREG; i++) begin
                    tag_q[i] <= '0;
                end
                busy_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (commit_hit) begin
                    busy_q[commit_rd] <= 1'b0;
                    tag_q[commit_rd]  <= '0;
                end
                // Placed after the commit clear so a same-register issue wins.
                if (issue_en) begin
                    busy_q[issue_rd] <= 1'b1;
                    tag_q[issue_rd]  <= issue_rob_idx;
                end
                cnt_q <= cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
            end
        end
    end

    assign busy_cnt = cnt_q;

    // Read ports see pre-edge state only; the bypass is deliberately not
    // gated by rdy_in so a stalled consumer still observes the retiring value.
    for (genvar p = 0; p < NRP; p++) begin : g_rp
        logic [AW-1:0] addr;
        logic          byp;
        logic          is_zero;

        assign addr    = rp_addr[p*AW +: AW];
        assign is_zero = (addr == '0);
        assign byp     = commit_valid && !is_zero && (commit_rd == addr)
                         && busy_q[addr] && (tag_q[addr] == commit_rob_idx);

        assign rp_val[p*XLEN +: XLEN]           = is_zero ? '0 : (byp ? commit_val : val_q[addr]);
        assign rp_busy[p]                       = !is_zero && !byp && busy_q[addr];
        assign rp_tag[p*ROB_WIDTH +: ROB_WIDTH] = rp_busy[p] ? tag_q[addr] : '0;
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Bench for rename_reg_file: directed vector table, hand-written flush and
// reset sequences, then randomized traffic against a behavioural model that
// tracks per-register value/busy/tag and counts busy registers directly.
module tb_rename_reg_file;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RW   = 4;
    localparam int NRP  = 2;
    localparam int AW   = 5;

    logic               clk_in = 1'b0;
    logic               rst_in, rdy_in, clr_in;
    logic               issue_valid;
    logic [AW-1:0]      issue_rd;
    logic [RW-1:0]      issue_rob_idx;
    logic               commit_valid;
    logic [AW-1:0]      commit_rd;
    logic [XLEN-1:0]    commit_val;
    logic [RW-1:0]      commit_rob_idx;
    logic [NRP*AW-1:0]  rp_addr;
    logic [NRP*XLEN-1:0] rp_val;
    logic [NRP-1:0]     rp_busy;
    logic [NRP*RW-1:0]  rp_tag;
    logic [AW:0]        busy_cnt;

    rename_reg_file #(.XLEN(XLEN), .NREG(NREG), .ROB_WIDTH(RW), .NRP(NRP)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_idx(issue_rob_idx),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_rob_idx(commit_rob_idx), .rp_addr(rp_addr), .rp_val(rp_val),
        .rp_busy(rp_busy), .rp_tag(rp_tag), .busy_cnt(busy_cnt)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the architectural state.
    logic [XLEN-1:0] m_val  [NREG];
    bit              m_busy [NREG];
    logic [RW-1:0]   m_tag  [NREG];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void mread(input logic [AW-1:0] a, output logic [XLEN-1:0] v,
                                  output logic b, output logic [RW-1:0] t);
        v = '0; b = 1'b0; t = '0;
        if (a != 0) begin
            if (commit_valid && commit_rd == a && m_busy[a] && m_tag[a] == commit_rob_idx) begin
                v = commit_val;
            end else begin
                v = m_val[a];
                b = m_busy[a];
                t = m_busy[a] ? m_tag[a] : '0;
            end
        end
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_step();
        bit hit;
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (rdy_in) begin
            hit = commit_valid && commit_rd != 0 && m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_idx;
            if (commit_valid && commit_rd != 0) m_val[commit_rd] = commit_val;
            if (clr_in) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            end else begin
                if (hit) m_busy[commit_rd] = 1'b0;
                if (issue_valid && issue_rd != 0) begin
                    m_busy[issue_rd] = 1'b1;
                    m_tag[issue_rd]  = issue_rob_idx;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rst_in = 0; rdy_in = 1; clr_in = 0;
        issue_valid = 0; issue_rd = '0; issue_rob_idx = '0;
        commit_valid = 0; commit_rd = '0; commit_val = '0; commit_rob_idx = '0;
    endtask

    task automatic check_model(input string name);
        logic [XLEN-1:0] v; logic b; logic [RW-1:0] t;
        for (int p = 0; p < NRP; p++) begin
            mread(rp_addr[p*AW +: AW], v, b, t);
            check({name, "_val"},  64'(rp_val[p*XLEN +: XLEN]), 64'(v));
            check({name, "_busy"}, 64'(rp_busy[p]), 64'(b));
            check({name, "_tag"},  64'(rp_tag[p*RW +: RW]), 64'(t));
        end
        check({name, "_cnt"}, 64'(busy_cnt), 64'(mcount()));
    endtask

    typedef struct {
        logic rdy, clr, iv;
        logic [AW-1:0] ird; logic [RW-1:0] itag;
        logic cv; logic [AW-1:0] crd; logic [XLEN-1:0] cval; logic [RW-1:0] ctag;
        logic [AW-1:0] a0, a1;
        logic [XLEN-1:0] v0; logic b0; logic [RW-1:0] t0;
        logic [XLEN-1:0] v1; logic b1; logic [RW-1:0] t1;
        logic [AW:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic rdy, clr, iv, input int ird, itag,
                                input logic cv, input int crd, input logic [XLEN-1:0] cval, input int ctag,
                                input int a0, a1,
                                input logic [XLEN-1:0] v0, input logic b0, input int t0,
                                input logic [XLEN-1:0] v1, input logic b1, input int t1,
                                input int cnt);
        vec_t r;
        r.rdy = rdy; r.clr = clr; r.iv = iv; r.ird = AW'(ird); r.itag = RW'(itag);
        r.cv = cv; r.crd = AW'(crd); r.cval = cval; r.ctag = RW'(ctag);
        r.a0 = AW'(a0); r.a1 = AW'(a1);
        r.v0 = v0; r.b0 = b0; r.t0 = RW'(t0);
        r.v1 = v1; r.b1 = b1; r.t1 = RW'(t1);
        r.cnt = (AW+1)'(cnt);
        return r;
    endfunction

    vec_t vt [19];

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
        // rdy clr iv ird itag | cv crd cval ctag | a0 a1 | v0 b0 t0 | v1 b1 t1 | cnt
        vt[0]  = mk(1,0,0,0,0, 0,0,32'h0,0,          5,0, 32'h0,0,0,        32'h0,0,0,        0);
        vt[1]  = mk(1,0,1,5,3, 0,0,32'h0,0,          5,5, 32'h0,0,0,        32'h0,0,0,        0);
        vt[2]  = mk(1,0,0,0,0, 0,0,32'h0,0,          5,5, 32'h0,1,3,        32'h0,1,3,        1);
        vt[3]  = mk(1,0,0,0,0, 1,5,32'hDEADBEEF,3,   5,5, 32'hDEADBEEF,0,0, 32'hDEADBEEF,0,0, 1);
        vt[4]  = mk(1,0,0,0,0, 0,0,32'h0,0,          5,0, 32'hDEADBEEF,0,0, 32'h0,0,0,        0);
        vt[5]  = mk(1,0,1,7,2, 0,0,32'h0,0,          7,5, 32'h0,0,0,        32'hDEADBEEF,0,0, 0);
        vt[6]  = mk(1,0,1,7,6, 0,0,32'h0,0,          7,0, 32'h0,1,2,        32'h0,0,0,        1);
        vt[7]  = mk(1,0,0,0,0, 1,7,32'h11,2,         7,0, 32'h0,1,6,        32'h0,0,0,        1);
        vt[8]  = mk(1,0,0,0,0, 0,0,32'h0,0,          7,0, 32'h11,1,6,       32'h0,0,0,        1);
        vt[9]  = mk(1,0,1,9,1, 0,0,32'h0,0,          9,0, 32'h0,0,0,        32'h0,0,0,        1);
        vt[10] = mk(1,0,1,9,4, 1,9,32'h99,1,         9,7, 32'h99,0,0,       32'h11,1,6,       2);
        vt[11] = mk(1,0,0,0,0, 0,0,32'h0,0,          9,7, 32'h99,1,4,       32'h11,1,6,       2);
        vt[12] = mk(1,0,1,0,5, 1,0,32'hFFFF,5,       0,0, 32'h0,0,0,        32'h0,0,0,        2);
        vt[13] = mk(1,0,0,0,0, 0,0,32'h0,0,          0,9, 32'h0,0,0,        32'h99,1,4,       2);
        vt[14] = mk(0,0,1,3,7, 0,0,32'h0,0,          3,0, 32'h0,0,0,        32'h0,0,0,        2);
        vt[15] = mk(0,0,0,0,0, 1,9,32'h55,4,         9,3, 32'h55,0,0,       32'h0,0,0,        2);
        vt[16] = mk(1,0,0,0,0, 0,0,32'h0,0,          9,3, 32'h99,1,4,       32'h0,0,0,        2);
        vt[17] = mk(1,0,0,0,0, 1,7,32'h77,6,         7,9, 32'h77,0,0,       32'h99,1,4,       2);
        vt[18] = mk(1,0,0,0,0, 0,0,32'h0,0,          7,9, 32'h77,0,0,       32'h99,1,4,       1);

        idle();
        rp_addr = '0;
        rst_in = 1;
        tick();
        idle();

        // Directed vector table.
        for (int i = 0; i < 19; i++) begin
            rdy_in = vt[i].rdy; clr_in = vt[i].clr;
            issue_valid = vt[i].iv; issue_rd = vt[i].ird; issue_rob_idx = vt[i].itag;
            commit_valid = vt[i].cv; commit_rd = vt[i].crd; commit_val = vt[i].cval;
            commit_rob_idx = vt[i].ctag;
            rp_addr = {vt[i].a1, vt[i].a0};
            #1;
            check($sformatf("vec%0d_v0", i), 64'(rp_val[XLEN-1:0]), 64'(vt[i].v0));
            check($sformatf("vec%0d_b0", i), 64'(rp_busy[0]), 64'(vt[i].b0));
            check($sformatf("vec%0d_t0", i), 64'(rp_tag[RW-1:0]), 64'(vt[i].t0));
            check($sformatf("vec%0d_v1", i), 64'(rp_val[2*XLEN-1:XLEN]), 64'(vt[i].v1));
            check($sformatf("vec%0d_b1", i), 64'(rp_busy[1]), 64'(vt[i].b1));
            check($sformatf("vec%0d_t1", i), 64'(rp_tag[2*RW-1:RW]), 64'(vt[i].t1));
            check($sformatf("vec%0d_cnt", i), 64'(busy_cnt), 64'(vt[i].cnt));
            tick();
        end
        idle();

        // Flush: rename x1..x4, retire x1, then flush alongside an issue to x8
        // and a retirement of x2.
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1; issue_rd = AW'(r); issue_rob_idx = RW'(r);
            tick();
        end
        idle();
        #1;
        check("clr_precnt", 64'(busy_cnt), 64'd5);
        commit_valid = 1; commit_rd = 5'd1; commit_val = 32'hA1; commit_rob_idx = 4'd1;
        tick();
        idle();
        clr_in = 1;
        issue_valid = 1; issue_rd = 5'd8; issue_rob_idx = 4'd9;
        commit_valid = 1; commit_rd = 5'd2; commit_val = 32'hB2; commit_rob_idx = 4'd2;
        tick();
        idle();
        rp_addr = {5'd2, 5'd8};
        #1;
        check("clr_cnt", 64'(busy_cnt), 64'd0);
        check("clr_x8_busy", 64'(rp_busy[0]), 64'd0);
        check("clr_x2_val", 64'(rp_val[2*XLEN-1:XLEN]), 64'hB2);
        check("clr_x2_busy", 64'(rp_busy[1]), 64'd0);
        rp_addr = {5'd9, 5'd1};
        #1;
        check("clr_x1_val", 64'(rp_val[XLEN-1:0]), 64'hA1);
        check("clr_x9_val", 64'(rp_val[2*XLEN-1:XLEN]), 64'h99);
        check("clr_x9_busy", 64'(rp_busy[1]), 64'd0);
        check("clr_x9_tag", 64'(rp_tag[2*RW-1:RW]), 64'd0);

        // Reset with ten registers busy and traffic on the same edge.
        for (int r = 10; r < 20; r++) begin
            issue_valid = 1; issue_rd = AW'(r); issue_rob_idx = RW'(r);
            tick();
        end
        idle();
        #1;
        check("rst_precnt", 64'(busy_cnt), 64'd10);
        rst_in = 1; clr_in = 1;
        issue_valid = 1; issue_rd = 5'd20; issue_rob_idx = 4'd3;
        commit_valid = 1; commit_rd = 5'd11; commit_val = 32'h1234; commit_rob_idx = 4'd11;
        tick();
        idle();
        #1;
        check("rst_cnt", 64'(busy_cnt), 64'd0);
        for (int r = 0; r < NREG; r++) begin
            rp_addr = {AW'(r), AW'(r)};
            #1;
            if (rp_val[XLEN-1:0] != 0 || rp_busy[0] || rp_tag[RW-1:0] != 0) begin
                n_fail++;
                $display("FAIL rst_x%0d: got val=%0h busy=%0b tag=%0h expected 0/0/0",
                         r, rp_val[XLEN-1:0], rp_busy[0], rp_tag[RW-1:0]);
            end
            n_tests++;
            check($sformatf("rst_same_x%0d", r),
                  64'({rp_val[2*XLEN-1:XLEN], rp_busy[1], rp_tag[2*RW-1:RW]}),
                  64'({rp_val[XLEN-1:0], rp_busy[0], rp_tag[RW-1:0]}));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            rst_in = ($urandom % 300) == 0;
            rdy_in = ($urandom % 10) != 0;
            clr_in = ($urandom % 40) == 0;
            issue_valid = $urandom % 2;
            issue_rd = AW'($urandom_range(0, 15));
            issue_rob_idx = RW'($urandom);
            commit_valid = $urandom % 2;
            r = $urandom_range(0, 15);
            commit_rd = AW'(r);
            commit_val = $urandom;
            commit_rob_idx = ($urandom % 4 != 0) ? m_tag[r] : RW'($urandom);
            rp_addr = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            if ($urandom % 4 == 0) rp_addr = {commit_rd, commit_rd};
            #1;
            check_model($sformatf("rand%0d", c));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
